aes128_key_schedule: RTL and testbench

Sequential AES-128 key schedule engine. Accepts a 128-bit cipher key over a valid/ready handshake, then drives one aes128_key_expansion_port instance for rounds 1..10, one round per clock. All 11 round keys are stored in an internal register file, which the downstream round datapath reads through a combinational index port.

---
 rtl/aes128_key_schedule.sv | 223 ++++++++++++++++++++++
 tb/tb_aes128_key_schedule.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_key_schedule.sv
// ---------------------------------------------------------------------------
// aes128_key_schedule
// Sequential AES-128 key schedule engine. A cipher key is accepted over a
// valid/ready handshake. The engine then expands it, one round per clock, into
// an 11-entry round key register file. The round datapath reads that file
// through a combinational index port.
//
// Ports:
//   clk         in   1    clock, rising edge
//   rst         in   1    synchronous reset, active-high
//   key_valid   in   1    cipher key on key_in is valid
//   key_ready   out  1    engine can accept a new key
//   key_in      in   128  cipher key, word 0 in bits [127:96]
//   busy        out  1    expansion in progress
//   keys_valid  out  1    all 11 round keys stored and stable
//   rk_idx      in   4    round key select, 0..10
//   rk          out  128  selected round key (combinational read, 0 for 11..15)
//
// Optional feature macro: AES128_KEY_SCHEDULE_CACHE_EN
//   When defined, a key handshake in READY whose key matches the stored key
//   is absorbed without re-expansion, and keys_valid stays high.
// ---------------------------------------------------------------------------
module aes128_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk
);

  localparam int unsigned AES128_ROUNDS_NUM = 10;
  localparam int unsigned AES128_KEY_SIZE   = 128;
  localparam int unsigned WORD_SIZE         = 32;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    logic [7:0] bb;
    acc = 8'h00;
    sh  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    gf_mul = acc;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    rotl1 = {x[6:0], x[7]};
  endfunction

  // S-box: multiplicative inverse as x^254 (maps 0 to 0), then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    logic [7:0] r1, r2, r3, r4;
    x2   = gf_mul(x, x);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    r1   = rotl1(inv);
    r2   = rotl1(r1);
    r3   = rotl1(r2);
    r4   = rotl1(r3);
    sbox = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [WORD_SIZE-1:0] sub_word(input logic [WORD_SIZE-1:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // One expansion round: previous round key -> next round key; round 0 or >10 yields 0
  function automatic logic [AES128_KEY_SIZE-1:0] key_expansion_port(
    input logic [CNT_W-1:0]           round_num,
    input logic [AES128_KEY_SIZE-1:0] key
  );
    logic [WORD_SIZE-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_num), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    if (round_num == '0 || round_num > CNT_W'(AES128_ROUNDS_NUM))
      key_expansion_port = '0;
    else
      key_expansion_port = {n0, n1, n2, n3};
  endfunction

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_cnt;
  logic [AES128_KEY_SIZE-1:0] r_rk [0:AES128_ROUNDS_NUM];
  logic                       r_key_ready;
  logic                       r_busy;
  logic                       r_keys_valid;
  logic                       w_key_ready_nxt;
  logic                       w_busy_nxt;
  logic                       w_keys_valid_nxt;
  logic                       w_hs;
  logic                       w_cache_hit;
  logic                       w_last_round;
  logic [CNT_W-1:0]           w_round_num;
  logic [AES128_KEY_SIZE-1:0] w_prev_key;
  logic [AES128_KEY_SIZE-1:0] w_new_key;

  assign w_hs         = key_valid & r_key_ready;
  assign w_last_round = (r_cnt == CNT_W'(AES128_ROUNDS_NUM));

  // Expansion port is only driven during EXPAND; elsewhere it sees round 0 and outputs 0
  assign w_round_num  = (r_state == ST_EXPAND) ? r_cnt : '0;
  assign w_prev_key   = (r_state == ST_EXPAND) ? r_rk[r_cnt - 4'd1] : '0;
  assign w_new_key    = key_expansion_port(w_round_num, w_prev_key);

`ifdef AES128_KEY_SCHEDULE_CACHE_EN
  logic [AES128_KEY_SIZE-1:0] r_last_key;
  logic                       r_cache_hit;

  // A repeat of the stored key while READY keeps the existing schedule
  assign w_cache_hit = (r_state == ST_READY) && (key_in == r_last_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_key  <= '0;
      r_cache_hit <= 1'b0;
    end else if (w_hs) begin
      r_last_key  <= key_in;
      r_cache_hit <= w_cache_hit;
    end
  end
`else
  assign w_cache_hit = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_key_ready_nxt  = 1'b1;
    w_busy_nxt       = 1'b0;
    w_keys_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_hs) w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_last_round) w_state_nxt = ST_READY;
      ST_READY:  if (w_hs && !w_cache_hit) w_state_nxt = ST_EXPAND;
      default:   w_state_nxt = ST_IDLE;
    endcase
    w_key_ready_nxt  = (w_state_nxt != ST_EXPAND);
    w_busy_nxt       = (w_state_nxt == ST_EXPAND);
    w_keys_valid_nxt = (w_state_nxt == ST_READY);
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_key_ready  <= w_key_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_keys_valid <= w_keys_valid_nxt;
    end
  end

  // Round counter and round key register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rk  <= '{default: '0};
    end else if (r_state == ST_EXPAND) begin
      r_rk[r_cnt] <= w_new_key;
      r_cnt       <= w_last_round ? '0 : r_cnt + 4'd1;
    end else if (w_hs && !w_cache_hit) begin
      r_rk[0] <= key_in;
      r_cnt   <= 4'd1;
    end
  end

  assign key_ready  = r_key_ready;
  assign busy       = r_busy;
  assign keys_valid = r_keys_valid;
  assign rk         = (rk_idx <= CNT_W'(AES128_ROUNDS_NUM)) ? r_rk[rk_idx] : '0;

endmodule

// File: tb/tb_aes128_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes128_key_schedule
// Scoreboard bench. An observer process models the handshake/timing and
// pushes a reference key schedule on every accepted key. A monitor process
// checks the status outputs each cycle. It also pops the scoreboard and sweeps
// the read port whenever a schedule completes or a reset occurs.
// ---------------------------------------------------------------------------
module tb_aes128_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;

  aes128_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk         (rk)
  );

  initial forever #20 clk = ~clk;

  // Reference tables built from the field arithmetic
  logic [7:0] sbox_t [256];
  logic [7:0] rcon_t [11];

  function automatic logic [7:0] gmul_ref(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int k = 14; k >= 8; k--)
      if (((p >> k) & 1) != 0) p = p ^ ('h11b << (k - 8));
    return 8'(p);
  endfunction

  initial begin
    int rc;
    for (int x = 0; x < 256; x++) begin
      int inv;
      logic [7:0] b, s, c;
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul_ref(x, y) == 8'h01) inv = y;
      b = 8'(inv);
      c = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      sbox_t[x] = s;
    end
    rc = 1;
    rcon_t[0] = 8'h00;
    for (int r = 1; r <= 10; r++) begin
      rcon_t[r] = 8'(rc);
      rc = int'(gmul_ref(rc, 2));
    end
  end

  // Textbook FIPS-197 word-by-word expansion; round key r sits at [r*128 +: 128]
  function automatic logic [1407:0] ref_schedule(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [1407:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
            ^ {rcon_t[i / 4], 24'h000000};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      s[r * 128 +: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return s;
  endfunction

  // Observer: timing model and scoreboard producer (reads only bench-driven inputs)
  int            cyc = 0;
  int            rst_cnt = 0;
  int            flush_mark = 0;
  logic          m_exp = 1'b0;
  logic          m_kv = 1'b0;
  int            m_left = 0;
  logic [127:0]  m_last = '0;
  logic [1407:0] sb_q [$];

  initial forever begin
    logic hit;
    @(posedge clk);
    cyc++;
    if (rst) begin
      rst_cnt++;
      flush_mark = sb_q.size();
      m_exp = 1'b0;
      m_kv = 1'b0;
      m_left = 0;
    end else if (key_valid && !m_exp) begin
      hit = 1'b0;
`ifdef AES128_KEY_SCHEDULE_CACHE_EN
      hit = m_kv && (key_in == m_last);
`endif
      if (!hit) begin
        sb_q.push_back(ref_schedule(key_in));
        m_exp = 1'b1;
        m_kv = 1'b0;
        m_left = 10;
        m_last = key_in;
      end
    end else if (m_exp) begin
      m_left--;
      if (m_left == 0) begin
        m_exp = 1'b0;
        m_kv = 1'b1;
      end
    end
  end

  // Monitor: owns all comparisons and counters
  int            n_cmp = 0;
  int            n_fail = 0;
  int            rd_ptr = 0;
  int            seen_rst = 0;
  logic          kv_prev = 1'b0;
  logic          done = 1'b0;
  logic [1407:0] exp_s;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic sweep(input logic [1407:0] s);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      e = (i <= 10) ? s[i * 128 +: 128] : '0;
      chk($sformatf("rk[%0d]", i), rk, e);
    end
    rk_idx = '0;
  endtask

  initial begin
    rk_idx = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("key_ready", 128'(key_ready), 128'(!m_exp));
        chk("busy", 128'(busy), 128'(m_exp));
        chk("keys_valid", 128'(keys_valid), 128'(m_kv));
      end
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        rd_ptr = flush_mark;
        sweep('0);
      end else if (m_kv && !kv_prev) begin
        if (rd_ptr < sb_q.size()) begin
          exp_s = sb_q[rd_ptr];
          rd_ptr++;
          sweep(exp_s);
        end else begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard_empty @cyc %0d: got keys_valid rise, expected no schedule", cyc);
        end
      end
      kv_prev = m_kv;
      if (done) begin
        chk("sb_drained", 128'(sb_q.size() - rd_ptr), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  // Stimulus
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_kv();
    int n;
    n = 0;
    @(negedge clk);
    while (keys_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [127:0] last_sent;
    rst = 1'b1;
    key_valid = 1'b0;
    key_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, then a different key held during EXPAND, then all-zero key back-to-back
    key_valid = 1'b1;
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(posedge clk);
    @(negedge clk);
    key_in = rand128();
    wait_kv();
    @(posedge clk);
    @(negedge clk);
    key_in = '0;
    wait_kv();
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    wait_kv();
    repeat (3) @(negedge clk);

    // Reset in the 5th EXPAND cycle
    key_valid = 1'b1;
    key_in = rand128();
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset together with key_valid: no key captured
    rst = 1'b1;
    key_valid = 1'b1;
    key_in = rand128();
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Random keys with small random gaps
    last_sent = '0;
    for (int i = 0; i < 4; i++) begin
      last_sent = rand128();
      key_valid = 1'b1;
      key_in = last_sent;
      @(negedge clk);
      key_valid = 1'b0;
      wait_kv();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef AES128_KEY_SCHEDULE_CACHE_EN
    // Repeat of the stored key is absorbed, a new key expands
    key_valid = 1'b1;
    key_in = last_sent;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    key_valid = 1'b1;
    key_in = rand128();
    @(negedge clk);
    key_valid = 1'b0;
    wait_kv();
`endif

    repeat (3) @(posedge clk);
    done = 1'b1;
  end

endmodule
